arbiter_1_to_n_route_buffer: RTL

ARBITER_1_TO_N_ROUTE_BUFFER -- requirements
Module: arbiter_1_to_n_route_buffer

---
 rtl/arbiter_1_to_n_route_buffer.sv | 112 +++++++++++
 1 files changed

// File: rtl/arbiter_1_to_n_route_buffer.sv
// rtl/arbiter_1_to_n_route_buffer.sv - request FIFO with a head register fanning out to N ports
// Define ARBITER_1_TO_N_MULTICAST_EN to accept any non-zero route; default accepts one-hot only.
module arbiter_1_to_n_route_buffer #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 512,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                            ap_clk,
   input  logic                            ap_rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_PORTS-1:0]            in_route,
   input  logic [DATA_WIDTH-1:0]           in_payload,
   output logic [NUM_PORTS-1:0]            out_valid,
   input  logic [NUM_PORTS-1:0]            out_ready,
   output logic [DATA_WIDTH-1:0]           out_payload,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
   output logic [15:0]                     drop_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [NUM_PORTS-1:0]  mem_route   [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_payload [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [CW-1:0]         count_next;
   logic                  ready_q;
   logic                  hr_valid;
   logic [NUM_PORTS-1:0]  hr_pending;
   logic [DATA_WIDTH-1:0] hr_payload;
   logic [15:0]           drop_q;

   logic                  route_legal;
   logic                  accept;
   logic                  push;
   logic                  drop;
   logic                  hr_done;
   logic                  pop;
   logic [NUM_PORTS-1:0]  pending_after;

   always_comb begin
`ifdef ARBITER_1_TO_N_MULTICAST_EN
      route_legal = (in_route != '0);
`else
      route_legal = $onehot(in_route);
`endif
   end

   assign accept        = in_valid & ready_q;
   assign push          = accept & route_legal;
   assign drop          = accept & ~route_legal;
   assign pending_after = hr_pending & ~out_ready;
   assign hr_done       = hr_valid & (pending_after == '0);
   // The head reloads on the same edge it retires, keeping one request per cycle.
   assign pop           = (count != '0) & (~hr_valid | hr_done);

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + CNT_ONE;
         2'b01:   count_next = count - CNT_ONE;
         default: count_next = count;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         ready_q    <= 1'b0;
         hr_valid   <= 1'b0;
         hr_pending <= '0;
         drop_q     <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         count   <= count_next;
         ready_q <= (count_next != FULL);
         if (pop) begin
            hr_valid   <= 1'b1;
            hr_pending <= mem_route[rd_ptr];
         end else if (hr_done) begin
            hr_valid   <= 1'b0;
            hr_pending <= '0;
         end else begin
            hr_pending <= pending_after;
         end
         if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      end
   end

   // Payload storage carries no reset so it maps onto plain RAM/flops.
   always_ff @(posedge ap_clk) begin
      if (push) begin
         mem_route[wr_ptr]   <= in_route;
         mem_payload[wr_ptr] <= in_payload;
      end
      if (pop) hr_payload <= mem_payload[rd_ptr];
   end

   assign in_ready    = ready_q;
   assign out_valid   = {NUM_PORTS{hr_valid}} & hr_pending;
   assign out_payload = hr_payload;
   assign fifo_count  = count;
   assign drop_count  = drop_q;
endmodule
